// File: rtl/csd_to_bin.sv
// csd_to_bin: MSB-first Horner decoder from CSD pos/neg digit masks to a two's-complement value.
// Define CSD_CANON_CHECK_EN to also flag adjacent nonzero digits in err_o.
module csd_to_bin #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [N-1:0] pos_i,
  input  logic [N-1:0] neg_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N:0]   result_o,
  output logic         err_o
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] pos_q, pos_d, neg_q, neg_d;
  logic [N:0] acc_q, acc_d, result_q, result_d;
  logic err_q, err_d, p, n, nz, adj;
  assign p = pos_q[cnt_q];
  assign n = neg_q[cnt_q];
  assign nz = p ^ n;
`ifdef CSD_CANON_CHECK_EN
  logic prev_q;
  assign adj = nz & prev_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_q <= 1'b0;
    else if (state_q == LOAD) prev_q <= 1'b0;
    else if (state_q == SHIFT) prev_q <= nz;
`else
  assign adj = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pos_d = pos_q;
    neg_d = neg_q;
    acc_d = acc_q;
    result_d = result_q;
    err_d = err_q;
    case (state_q)
      IDLE: state_d = start_i ? LOAD : IDLE;
      LOAD: begin
        pos_d = pos_i;
        neg_d = neg_i;
        acc_d = '0;
        err_d = 1'b0;
        cnt_d = CW'(N - 1);
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d = {acc_q[N-1:0], 1'b0} + (nz ? (p ? (N+1)'(1) : {(N+1){1'b1}}) : '0);
        err_d = err_q | (p & n) | adj;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        result_d = (cnt_q == '0) ? acc_d : result_q;
        state_d = (cnt_q == '0) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pos_q <= '0;
      neg_q <= '0;
      acc_q <= '0;
      result_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      neg_q <= neg_d;
      acc_q <= acc_d;
      result_q <= result_d;
      err_q <= err_d;
    end
  assign busy_o = (state_q == LOAD) || (state_q == SHIFT);
  assign done_o = (state_q == DONE);
  assign result_o = result_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_csd_to_bin.sv
// tb_csd_to_bin: directed vectors with a scoreboard queue checked by a done-driven monitor.
module tb_csd_to_bin;
  typedef struct {
    logic [8:0] r;
    logic e;
    int c;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
  logic [7:0] pos_i = '0, neg_i = '0;
  logic busy_o, done_o, err_o;
  logic [8:0] result_o;
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic canon;
  csd_to_bin #(.N(8)) dut (.clk(clk), .rst_n(rst_n), .start_i(start_i), .pos_i(pos_i),
    .neg_i(neg_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .err_o(err_o));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask
  always @(negedge clk)
    if (rst_n && done_o) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t x;
        x = q.pop_front();
        chk("result", int'(result_o), int'(x.r));
        chk("err", int'(err_o), int'(x.e));
        chk("done_cycle", cyc, x.c);
        chk("busy_in_done", int'(busy_o), 0);
      end
    end
  task automatic issue(input logic [7:0] p, input logic [7:0] n, input logic [8:0] r, input logic e);
    exp_t x;
    @(negedge clk);
    pos_i = p;
    neg_i = n;
    start_i = 1'b1;
    x.r = r;
    x.e = e;
    x.c = cyc + 10;
    q.push_back(x);
    @(negedge clk);
    start_i = 1'b0;
  endtask
  task automatic wait_done();
    int k;
    for (k = 0; k < 20 && !done_o; k++) @(negedge clk);
    if (!done_o) chk("done_timeout", 0, 1);
  endtask
  task automatic run(input logic [7:0] p, input logic [7:0] n, input logic [8:0] r, input logic e);
    issue(p, n, r, e);
    chk("busy_in_load", int'(busy_o), 1);
    wait_done();
  endtask
  initial begin
`ifdef CSD_CANON_CHECK_EN
    canon = 1'b1;
`else
    canon = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_result", int'(result_o), 0);
    chk("rst_err", int'(err_o), 0);
    rst_n = 1'b1;
    run(8'h80, 8'h00, 9'h080, 1'b0);
    run(8'hAA, 8'h00, 9'h0AA, 1'b0);
    run(8'h00, 8'hAA, 9'h156, 1'b0);
    run(8'h80, 8'h01, 9'h07F, 1'b0);
    run(8'h03, 8'h00, 9'h003, canon);
    run(8'h10, 8'h10, 9'h000, 1'b1);
    run(8'h00, 8'hFF, 9'h101, canon);
    run(8'hFF, 8'h00, 9'h0FF, canon);
    issue(8'h80, 8'h00, 9'h080, 1'b0);
    @(negedge clk);
    start_i = 1'b1;
    pos_i = 8'hFF;
    neg_i = 8'h01;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();
    repeat (15) @(negedge clk);
    @(negedge clk);
    pos_i = 8'hFF;
    neg_i = 8'h00;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_abort", int'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_result", int'(result_o), 0);
    repeat (14) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(8'h01, 8'h00, 9'h001, 1'b0);
    repeat (15) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
